fetch_queue: RTL and testbench

- Instruction buffer between fetch and decode; decouples fetch from decode stalls.
- Accepts fetch_data_t packets (pc, instr, error) from fetch and presents them in order to decode with a valid/ready handshake.
- in_ready back-pressures fetch; fetch ORs !in_ready into its stop input.
- A redirect (branch or flushall) discards all buffered instructions in one cycle.

---
 rtl/fetch_queue_pkg.sv | 36 +++
 rtl/fetch_queue_if.sv | 24 ++
 rtl/fetch_queue.sv | 102 ++++++++++
 tb/tb_fetch_queue.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch-to-decode instruction buffer.
// Optional same-cycle bypass is enabled by defining FETCHQ_BYPASS_EN.
package common;
  localparam int unsigned FETCHQ_DEPTH = 4;
endpackage

package pipes;
  typedef enum logic [1:0] {
    NOERROR            = 2'd0,
    INSTR_MISALIGN     = 2'd1,
    INSTR_ACCESS_FAULT = 2'd2,
    INSTR_PAGE_FAULT   = 2'd3
  } fetch_err_e;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
    fetch_err_e  error;
  } fetch_data_t;
endpackage

package fetch_queue_pkg;
  import pipes::*;

  // Stored payload; valid is implied by occupancy.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    fetch_err_e  error;
  } fetch_entry_t;

  function automatic bit depth_ok(int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch, the fetch queue and decode.
// Optional same-cycle bypass is enabled by defining FETCHQ_BYPASS_EN.
interface fetch_queue_if
  import pipes::*;
#(
  parameter int unsigned DEPTH = common::FETCHQ_DEPTH
);
  logic                     flush;
  fetch_data_t              in_data;
  logic                     in_ready;
  fetch_data_t              out_data;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output flush, in_data, out_ready,
    input  in_ready, out_data, count
  );

  modport slave (
    input  flush, in_data, out_ready,
    output in_ready, out_data, count
  );
endinterface

// File: rtl/fetch_queue.sv
// In-order instruction buffer decoupling fetch from decode stalls; flush drops all entries.
// Defining FETCHQ_BYPASS_EN lets an empty queue forward in_data to out_data in the same cycle.
module fetch_queue
  import pipes::*;
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = common::FETCHQ_DEPTH
) (
  input logic           clk,
  input logic           reset,
  fetch_queue_if.slave  fq
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of two and >= 2");
  end

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic        empty, full;
  logic        bypass_take;
  logic        push, pop;
  fetch_data_t out_data;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));

`ifdef FETCHQ_BYPASS_EN
  // An empty queue hands the packet straight to decode when decode is ready.
  assign bypass_take = empty && fq.in_data.valid && fq.out_ready && !fq.flush;
`else
  assign bypass_take = 1'b0;
`endif

  // in_ready depends only on state, never on out_ready.
  assign fq.in_ready = !full;
  assign push = fq.in_data.valid && !full && !fq.flush && !bypass_take;
  assign pop  = !empty && fq.out_ready && !fq.flush;

  always_comb begin
    out_data = '0;
    if (!empty) begin
      out_data.valid = 1'b1;
      out_data.pc    = mem_q[rd_ptr_q].pc;
      out_data.instr = mem_q[rd_ptr_q].instr;
      out_data.error = mem_q[rd_ptr_q].error;
    end
`ifdef FETCHQ_BYPASS_EN
    else if (fq.in_data.valid) begin
      out_data = fq.in_data;
    end
`endif
  end

  assign fq.out_data = out_data;
  assign fq.count    = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (fq.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q].pc    <= fq.in_data.pc;
      mem_q[wr_ptr_q].instr <= fq.in_data.instr;
      mem_q[wr_ptr_q].error <= fq.in_data.error;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4).
module tb_fetch_queue;
  import pipes::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [63:0] exp_q[$];
  logic [63:0] next_pc;

  fetch_queue_if #(.DEPTH(4)) fq ();

  fetch_queue #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .fq    (fq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] instr,
                       input fetch_err_e err);
    fq.in_data.valid = v;
    fq.in_data.pc    = pc;
    fq.in_data.instr = instr;
    fq.in_data.error = err;
  endtask

  initial begin
    reset        = 1'b1;
    fq.flush     = 1'b0;
    fq.out_ready = 1'b0;
    drive(1'b0, 64'h0, 32'h0, NOERROR);
    step();
    step();
    reset = 1'b0;
    step();

    // Reset / idle state
    check("rst_count", 64'(fq.count), 64'd0);
    check("rst_valid", 64'(fq.out_data.valid), 64'd0);
    check("rst_in_ready", 64'(fq.in_ready), 64'd1);
    check("rst_error", 64'(fq.out_data.error), 64'(NOERROR));
    check("rst_pc", fq.out_data.pc, 64'h0);

    // Single push, then pop
    drive(1'b1, 64'h8000_0000, 32'h0000_0013, NOERROR);
`ifdef FETCHQ_BYPASS_EN
    check("push1_same_cycle_valid", 64'(fq.out_data.valid), 64'd1);
`else
    check("push1_same_cycle_valid", 64'(fq.out_data.valid), 64'd0);
`endif
    step();
    drive(1'b0, 64'h0, 32'h0, NOERROR);
    check("push1_valid", 64'(fq.out_data.valid), 64'd1);
    check("push1_pc", fq.out_data.pc, 64'h8000_0000);
    check("push1_instr", 64'(fq.out_data.instr), 64'h13);
    check("push1_count", 64'(fq.count), 64'd1);
    fq.out_ready = 1'b1;
    step();
    fq.out_ready = 1'b0;
    check("pop1_count", 64'(fq.count), 64'd0);
    check("pop1_valid", 64'(fq.out_data.valid), 64'd0);

    // Fill to DEPTH, 5th packet refused, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h8000_0000 + 64'(4 * i), 32'h0000_0013, NOERROR);
      step();
    end
    drive(1'b1, 64'h8000_0010, 32'h0000_0013, NOERROR);
    check("full_count", 64'(fq.count), 64'd4);
    check("full_in_ready", 64'(fq.in_ready), 64'd0);
    step();
    check("full_5th_refused", 64'(fq.count), 64'd4);
    drive(1'b0, 64'h0, 32'h0, NOERROR);
    fq.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_pc%0d", i), fq.out_data.pc, 64'h8000_0000 + 64'(4 * i));
      step();
      if (i == 0) check("drain_in_ready", 64'(fq.in_ready), 64'd1);
    end
    fq.out_ready = 1'b0;
    check("drain_count", 64'(fq.count), 64'd0);
    check("drain_valid", 64'(fq.out_data.valid), 64'd0);

    // Steady state at count=2: push and pop every cycle, pointers wrap
    next_pc = 64'h9000_0000;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, next_pc, 32'h0000_0013, NOERROR);
      exp_q.push_back(next_pc);
      next_pc += 64'd4;
      step();
    end
    check("steady_fill_count", 64'(fq.count), 64'd2);
    fq.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, next_pc, 32'h0000_0013, NOERROR);
      check($sformatf("steady_pc%0d", i), fq.out_data.pc, exp_q[0]);
      step();
      void'(exp_q.pop_front());
      exp_q.push_back(next_pc);
      next_pc += 64'd4;
    end
    fq.out_ready = 1'b0;
    check("steady_count", 64'(fq.count), 64'd2);
    check("steady_head", fq.out_data.pc, exp_q[0]);

    // count=3 then flush with a packet presented
    drive(1'b1, next_pc, 32'h0000_0013, NOERROR);
    step();
    check("preflush_count", 64'(fq.count), 64'd3);
    fq.flush     = 1'b1;
    fq.out_ready = 1'b1;
    drive(1'b1, 64'hDEAD_0000, 32'hDEAD_BEEF, NOERROR);
    step();
    fq.flush     = 1'b0;
    fq.out_ready = 1'b0;
    drive(1'b0, 64'h0, 32'h0, NOERROR);
    check("flush_count", 64'(fq.count), 64'd0);
    check("flush_valid", 64'(fq.out_data.valid), 64'd0);
    step();
    check("flush_pkt_absent", 64'(fq.count), 64'd0);

    // Error passes through untouched
    drive(1'b1, 64'h8000_0002, 32'h1234_5678, INSTR_MISALIGN);
    step();
    drive(1'b0, 64'h0, 32'h0, NOERROR);
    check("err_valid", 64'(fq.out_data.valid), 64'd1);
    check("err_pc", fq.out_data.pc, 64'h8000_0002);
    check("err_instr", 64'(fq.out_data.instr), 64'h1234_5678);
    check("err_error", 64'(fq.out_data.error), 64'(INSTR_MISALIGN));
    fq.out_ready = 1'b1;
    step();
    check("err_pop_count", 64'(fq.count), 64'd0);

    // Empty with out_ready: no underflow
    step();
    check("underflow_count", 64'(fq.count), 64'd0);
    check("underflow_in_ready", 64'(fq.in_ready), 64'd1);
    fq.out_ready = 1'b0;

    // Reset mid-operation
    drive(1'b1, 64'h8000_0100, 32'h0000_0013, NOERROR);
    step();
    step();
    drive(1'b0, 64'h0, 32'h0, NOERROR);
    check("midrst_pre_count", 64'(fq.count), 64'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_count", 64'(fq.count), 64'd0);
    check("midrst_valid", 64'(fq.out_data.valid), 64'd0);

`ifdef FETCHQ_BYPASS_EN
    // Bypass: empty queue, decode ready, same-cycle forward
    fq.out_ready = 1'b1;
    drive(1'b1, 64'h8000_0010, 32'h0000_0013, NOERROR);
    #1;
    check("byp_valid", 64'(fq.out_data.valid), 64'd1);
    check("byp_pc", fq.out_data.pc, 64'h8000_0010);
    check("byp_count", 64'(fq.count), 64'd0);
    step();
    drive(1'b0, 64'h0, 32'h0, NOERROR);
    fq.out_ready = 1'b0;
    check("byp_count_after", 64'(fq.count), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
